// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
//
// Request/response handshake between one bus master and the memory bus
// arbiter. One instance per master port.
//
// Signals:
//   req    master -> arbiter  request, held high until ack
//   we     master -> arbiter  1 = write, 0 = read
//   addr   master -> arbiter  byte address
//   wdata  master -> arbiter  write data
//   rdata  arbiter -> master  registered read data, held until the next read
//   ack    arbiter -> master  one-cycle completion pulse
//
// Modports:
//   master  the requesting side (CPU port, loader/DMA port)
//   slave   the arbiter side
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-master arbiter and access sequencer for the shared byte-wide memory bus.
// Master 0 is the CPU memory port, master 1 the external loader/DMA port.
// Each granted transaction holds one memory strobe for WAIT_STATES+1 cycles,
// then returns a one-cycle ack (and, for reads, registered data) to the winner.
//
// Parameters:
//   WAIT_STATES  extra strobe cycles beyond the first (0..15)
//   ADDR_W       address width
//   DATA_W       data width
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   m0         master 0 handshake (mem_bus_arbiter_if.slave)
//   m1         master 1 handshake (mem_bus_arbiter_if.slave)
//   mem_addr   registered memory address, stable for the whole access
//   mem_wdata  registered memory write data
//   mem_rdata  memory read data, captured on the last strobe cycle of a read
//   mem_out    memory read strobe
//   mem_in     memory write strobe
//   owner      current bus owner: 00 none, 01 master 0, 10 master 1
//
// Build option:
//   MEM_BUS_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests are granted
//                               to the master opposite the previous grant;
//                               otherwise master 0 always wins contention.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   m0,
    mem_bus_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               mem_out,
    output logic               mem_in,
    output logic [1:0]         owner
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    localparam logic ROUND_ROBIN = 1'b1;
`else
    localparam logic ROUND_ROBIN = 1'b0;
`endif

    logic [1:0]        state;
    logic [3:0]        wait_cnt;
    logic              we_q;
    logic              last_grant;   // 1 = master 1 was granted last

    logic              grant_m1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Winner selection, only consumed in IDLE. On contention the fixed-priority
    // build hands the bus to master 0; round robin picks the master opposite
    // last_grant, which resets to master 1 so master 0 wins first.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_m1 = 1'b0;
        if (m0.req && m1.req) begin
            grant_m1 = ROUND_ROBIN & ~last_grant;
        end else if (m1.req) begin
            grant_m1 = 1'b1;
        end
    end

    assign sel_we    = grant_m1 ? m1.we    : m0.we;
    assign sel_addr  = grant_m1 ? m1.addr  : m0.addr;
    assign sel_wdata = grant_m1 ? m1.wdata : m0.wdata;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            we_q       <= 1'b0;
            last_grant <= 1'b1;
            owner      <= OWNER_NONE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_out    <= 1'b0;
            mem_in     <= 1'b0;
            m0.ack     <= 1'b0;
            m1.ack     <= 1'b0;
            m0.rdata   <= '0;
            m1.rdata   <= '0;
        end else begin
            // Acks are single-cycle pulses; only the ACCESS->DONE edge raises one.
            m0.ack <= 1'b0;
            m1.ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (m0.req || m1.req) begin
                        state      <= ST_ACCESS;
                        wait_cnt   <= WAIT_INIT;
                        last_grant <= grant_m1;
                        owner      <= grant_m1 ? OWNER_M1 : OWNER_M0;
                        we_q       <= sel_we;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        // Strobes come up together with the address so the
                        // memory sees a registered, glitch-free access.
                        mem_out    <= ~sel_we;
                        mem_in     <= sel_we;
                    end
                end

                ST_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= ST_DONE;
                        mem_out <= 1'b0;
                        mem_in  <= 1'b0;
                        if (owner == OWNER_M1) begin
                            m1.ack <= 1'b1;
                            if (!we_q) begin
                                m1.rdata <= mem_rdata;
                            end
                        end else begin
                            m0.ack <= 1'b1;
                            if (!we_q) begin
                                m0.rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                ST_DONE: begin
                    // Requests are ignored here: the winner is still dropping
                    // its req after seeing ack.
                    state <= ST_IDLE;
                    owner <= OWNER_NONE;
                end

                default: begin
                    state   <= ST_IDLE;
                    owner   <= OWNER_NONE;
                    mem_out <= 1'b0;
                    mem_in  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter. Two instances: dut with WAIT_STATES=1
// for the read/write/contention/reset scenarios and dut0 with WAIT_STATES=0
// for back-to-back reads. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) m0_if ();
    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) m1_if ();
    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) z0_if ();
    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) z1_if ();

    logic [15:0] mem_addr,  z_mem_addr;
    logic [7:0]  mem_wdata, z_mem_wdata;
    logic [7:0]  mem_rdata, z_mem_rdata;
    logic        mem_out,   z_mem_out;
    logic        mem_in,    z_mem_in;
    logic [1:0]  owner,     z_owner;

    mem_bus_arbiter #(.WAIT_STATES(1), .ADDR_W(16), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_out   (mem_out),
        .mem_in    (mem_in),
        .owner     (owner)
    );

    mem_bus_arbiter #(.WAIT_STATES(0), .ADDR_W(16), .DATA_W(8)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .m0        (z0_if),
        .m1        (z1_if),
        .mem_addr  (z_mem_addr),
        .mem_wdata (z_mem_wdata),
        .mem_rdata (z_mem_rdata),
        .mem_out   (z_mem_out),
        .mem_in    (z_mem_in),
        .owner     (z_owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Steps falling edges until either master of dut sees ack, or the budget runs out.
    task automatic wait_ack(input int budget, output int who, output int cycles);
        who    = -1;
        cycles = 0;
        while (who < 0 && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (m0_if.ack)      who = 0;
            else if (m1_if.ack) who = 1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int who;
        int cyc;
        int exp_who;

        m0_if.req = 0; m0_if.we = 0; m0_if.addr = 0; m0_if.wdata = 0;
        m1_if.req = 0; m1_if.we = 0; m1_if.addr = 0; m1_if.wdata = 0;
        z0_if.req = 0; z0_if.we = 0; z0_if.addr = 0; z0_if.wdata = 0;
        z1_if.req = 0; z1_if.we = 0; z1_if.addr = 0; z1_if.wdata = 0;
        mem_rdata = 8'h00;
        z_mem_rdata = 8'h00;

        // ---------------- reset state ----------------
        rst = 1'b0;
        repeat (3) step();
        check("rst_mem_out",  32'(mem_out),     32'h0);
        check("rst_mem_in",   32'(mem_in),      32'h0);
        check("rst_owner",    32'(owner),       32'h0);
        check("rst_mem_addr", 32'(mem_addr),    32'h0);
        check("rst_acks",     32'({m0_if.ack, m1_if.ack}), 32'h0);
        check("rst_rdata",    32'({m0_if.rdata, m1_if.rdata}), 32'h0);
        rst = 1'b1;
        step();

        // ---------------- single read, m0 ----------------
        m0_if.req = 1; m0_if.we = 0; m0_if.addr = 16'h1234;
        mem_rdata = 8'hA5;
        step();
        check("rd_c1_mem_out", 32'(mem_out),  32'h1);
        check("rd_c1_mem_in",  32'(mem_in),   32'h0);
        check("rd_c1_addr",    32'(mem_addr), 32'h1234);
        check("rd_c1_owner",   32'(owner),    32'h1);
        check("rd_c1_ack",     32'(m0_if.ack), 32'h0);
        step();
        check("rd_c2_mem_out", 32'(mem_out),  32'h1);
        check("rd_c2_ack",     32'(m0_if.ack), 32'h0);
        step();
        check("rd_c3_mem_out", 32'(mem_out),  32'h0);
        check("rd_c3_ack",     32'(m0_if.ack), 32'h1);
        check("rd_c3_m1_ack",  32'(m1_if.ack), 32'h0);
        check("rd_c3_rdata",   32'(m0_if.rdata), 32'hA5);
        check("rd_c3_owner",   32'(owner),    32'h1);
        m0_if.req = 0;
        step();
        check("rd_c4_owner",   32'(owner),    32'h0);
        check("rd_c4_ack",     32'(m0_if.ack), 32'h0);
        check("rd_c4_rdata",   32'(m0_if.rdata), 32'hA5);

        // ---------------- single write, m1 ----------------
        m1_if.req = 1; m1_if.we = 1; m1_if.addr = 16'h8001; m1_if.wdata = 8'h3C;
        mem_rdata = 8'hEE;
        step();
        check("wr_c1_mem_in",  32'(mem_in),    32'h1);
        check("wr_c1_mem_out", 32'(mem_out),   32'h0);
        check("wr_c1_addr",    32'(mem_addr),  32'h8001);
        check("wr_c1_wdata",   32'(mem_wdata), 32'h3C);
        check("wr_c1_owner",   32'(owner),     32'h2);
        // Inputs change mid-access; the latched copy must stay on the bus.
        m1_if.addr = 16'h0000; m1_if.wdata = 8'hFF; m1_if.we = 0;
        step();
        check("wr_c2_mem_in",  32'(mem_in),    32'h1);
        check("wr_c2_mem_out", 32'(mem_out),   32'h0);
        check("wr_c2_addr",    32'(mem_addr),  32'h8001);
        check("wr_c2_wdata",   32'(mem_wdata), 32'h3C);
        step();
        check("wr_c3_mem_in",  32'(mem_in),    32'h0);
        check("wr_c3_mem_out", 32'(mem_out),   32'h0);
        check("wr_c3_ack",     32'(m1_if.ack), 32'h1);
        check("wr_c3_m0_ack",  32'(m0_if.ack), 32'h0);
        check("wr_c3_rdata",   32'(m1_if.rdata), 32'h00);
        m1_if.req = 0;
        step();
        check("wr_c4_ack",     32'(m1_if.ack), 32'h0);
        check("wr_c4_owner",   32'(owner),     32'h0);

        // ---------------- contention, both hold req ----------------
        // last grant was m1, so m0 wins in either build.
        m0_if.req = 1; m0_if.we = 0; m0_if.addr = 16'h0010;
        m1_if.req = 1; m1_if.we = 0; m1_if.addr = 16'h0020;
        mem_rdata = 8'h5A;
        step();
        check("ct_c1_owner", 32'(owner),    32'h1);
        check("ct_c1_addr",  32'(mem_addr), 32'h0010);
        wait_ack(10, who, cyc);
        check("ct_first_who",    32'(who), 32'd0);
        check("ct_first_cycles", 32'(cyc), 32'd2);
        check("ct_first_rdata",  32'(m0_if.rdata), 32'h5A);
        m0_if.req = 0;
        mem_rdata = 8'hC3;
        wait_ack(10, who, cyc);
        check("ct_second_who",    32'(who), 32'd1);
        check("ct_second_cycles", 32'(cyc), 32'd4);
        check("ct_second_rdata",  32'(m1_if.rdata), 32'hC3);
        check("ct_m0_rdata_kept", 32'(m0_if.rdata), 32'h5A);
        m1_if.req = 0;
        step();
        check("ct_idle_owner", 32'(owner), 32'h0);

        // ---------------- continuous re-request, 4 transactions ----------------
        m0_if.req = 1; m0_if.we = 0; m0_if.addr = 16'h0200;
        m1_if.req = 1; m1_if.we = 0; m1_if.addr = 16'h0300;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
            exp_who = k % 2;
`else
            exp_who = 0;
`endif
            wait_ack(10, who, cyc);
            check("cc_who",    32'(who), 32'(exp_who));
            check("cc_cycles", 32'(cyc), (k == 0) ? 32'd3 : 32'd4);
        end
        m0_if.req = 0;
        m1_if.req = 0;
        step();
        step();
        check("cc_idle_owner", 32'(owner), 32'h0);

        // ---------------- reset mid-ACCESS ----------------
        m0_if.req = 1; m0_if.we = 0; m0_if.addr = 16'h0BEE;
        mem_rdata = 8'h77;
        step();
        check("rs_c1_mem_out", 32'(mem_out), 32'h1);
        rst = 1'b0;
        step();
        check("rs_strobes", 32'({mem_out, mem_in}), 32'h0);
        check("rs_owner",   32'(owner),     32'h0);
        check("rs_ack",     32'(m0_if.ack), 32'h0);
        check("rs_rdata",   32'(m0_if.rdata), 32'h00);
        rst = 1'b1;
        wait_ack(10, who, cyc);
        check("rs_resume_who",    32'(who), 32'd0);
        check("rs_resume_cycles", 32'(cyc), 32'd3);
        check("rs_resume_rdata",  32'(m0_if.rdata), 32'h77);
        m0_if.req = 0;
        step();

        // ---------------- WAIT_STATES=0, back-to-back reads ----------------
        z0_if.req = 1; z0_if.we = 0; z0_if.addr = 16'h0100;
        z_mem_rdata = 8'h01;
        for (int k = 0; k < 3; k++) begin
            step();
            check("z_strobe_on",  32'(z_mem_out),  32'h1);
            check("z_addr",       32'(z_mem_addr), 32'h0100 + 32'(k));
            check("z_ack_low",    32'(z0_if.ack),  32'h0);
            step();
            check("z_strobe_off", 32'(z_mem_out),  32'h0);
            check("z_ack",        32'(z0_if.ack),  32'h1);
            check("z_rdata",      32'(z0_if.rdata), 32'(k + 1));
            if (k == 2) begin
                z0_if.req = 0;
            end else begin
                z0_if.addr  = 16'h0100 + 16'(k + 1);
                z_mem_rdata = 8'(k + 2);
            end
            step();
            check("z_idle_ack",   32'(z0_if.ack),  32'h0);
            check("z_idle_strobe", 32'(z_mem_out), 32'h0);
            check("z_addr_held",  32'(z_mem_addr), 32'h0100 + 32'(k));
        end
        step();
        check("z_final_owner", 32'(z_owner), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and access sequencer for the shared 8-bit memory bus (16-bit address, mem_in/mem_out strobes).
- Master 0 is the CPU memory port; master 1 is the external loader/DMA port (boot upload, debug peek/poke).
- Serialises single-byte read/write transactions, generates timed memory strobes with configurable wait states, and returns read data and a one-cycle acknowledge to the winning master.

Parameters:
- WAIT_STATES, 1, extra cycles the memory strobe is held beyond the first (legal 0..15).
- ADDR_W, 16, address width.
- DATA_W, 8, data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low (sampled on clk rising edge; 0 = reset).
- m0_req  input  1  master 0 request; held high until m0_ack.
- m0_we  input  1  master 0 direction, 1 = write, 0 = read.
- m0_addr  input  ADDR_W  master 0 address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_rdata  output  DATA_W  master 0 read data (registered).
- m0_ack  output  1  master 0 transaction complete, one-cycle pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.
- mem_out  output  1  memory read strobe (memory drives data).
- mem_in  output  1  memory write strobe.
- owner  output  2  current bus owner: 00 none, 01 master 0, 10 master 1.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE.
  - All outputs 0: acks, strobes, mem_addr, mem_wdata, both rdata, owner.
  - last_grant=1.
  - Reset mid-transaction aborts it: strobes low after that edge, no ack issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Strobes low; owner=00.
  - If any req is high at the edge: pick the winner, latch its addr/wdata/we into internal registers, set owner, load wait counter = WAIT_STATES, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_addr/mem_wdata are driven from the latched values, stable for the whole access.
  - mem_out = ~we_latched; mem_in = we_latched. Exactly one strobe is high.
  - Counter decrements each cycle. When the counter is 0 at an edge: on a read, capture mem_rdata into the winner's rdata; go to DONE.
  - ACCESS therefore lasts WAIT_STATES+1 cycles.
- DONE:
  - Strobes low; winner's ack=1 for exactly this cycle; owner still valid.
  - req inputs are ignored. Next state is IDLE.
- Latency: request sampled in IDLE at edge 0 → ack high in cycle WAIT_STATES+2 after that edge. With WAIT_STATES=1, ack is in the third cycle.
- Masters must drop req in the cycle after seeing ack. A req still high in the following IDLE cycle is a new transaction.
- Request inputs are sampled only in IDLE. Changes to addr/wdata/we during ACCESS have no effect (latched copy is used).
- rdata holds its value until the next completed read by the same master. Writes do not modify rdata.
- The non-winning master's ack stays 0. Its pending req waits in IDLE for the next arbitration.
- Default arbitration is fixed priority: master 0 wins when both request.
- last_grant updates on every grant.
- Strobe, address and data outputs are registered (no combinational path from req to memory).

Optional Feature:
- Macro: MEM_BUS_ARB_ROUND_ROBIN_EN.
- Defined: when both req are high in IDLE, the grant goes to the master opposite last_grant. A single requester always wins. After reset, master 0 wins the first contention.
- Undefined: fixed priority to master 0. last_grant is still kept but unused. Master 1 can starve under continuous master 0 traffic.

Test Plan:
- Single read, WAIT_STATES=1: m0 reads addr 0x1234, mem_rdata=0xA5 → mem_out high for 2 cycles with mem_addr=0x1234, m0_ack pulse in cycle 3, m0_rdata=0xA5, owner 01 during the access, then 00.
- Single write: m1 writes 0x3C to 0x8001 → mem_in high for 2 cycles, mem_wdata=0x3C, m1_ack pulse once, m1_rdata unchanged, mem_out never high.
- Contention, macro undefined: m0 and m1 both request at the same edge and hold req → m0 serviced first, m1 serviced immediately after; m1 retained its request.
- Contention with MEM_BUS_ARB_ROUND_ROBIN_EN, both masters continuously re-requesting → grants alternate m0, m1, m0, m1 over 4 transactions.
- Reset mid-ACCESS: rst=0 during the first strobe cycle of a read → next cycle strobes=0, owner=00, no ack. After release, the same held req completes normally.
- WAIT_STATES=0 and back-to-back: m0 issues 3 consecutive reads → each strobe lasts 1 cycle, acks are 3 cycles apart, addresses change only between transactions.
